// File: rtl/reg_file_seq_if.sv
// Command and register-file bus between the control unit, the sequencer and
// the 8x16 register file. The sequencer takes the slave side; the control unit
// and the register file together form the master side.
interface reg_file_seq_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_dst;
  logic [AW-1:0] cmd_src_a;
  logic [AW-1:0] cmd_src_b;
  logic [DW-1:0] cmd_imm;
  logic [AW-1:0] rf_rd_addr_a;
  logic [AW-1:0] rf_rd_addr_b;
  logic [DW-1:0] rf_d_out_a;
  logic [DW-1:0] rf_d_out_b;
  logic          rf_wr;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_d_in;
  logic          done;
  logic [DW-1:0] result;
  logic          carry;
  logic          zero;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
    output rf_d_out_a, rf_d_out_b,
    input  cmd_ready, rf_rd_addr_a, rf_rd_addr_b, rf_wr, rf_wr_addr, rf_d_in,
    input  done, result, carry, zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
    input  rf_d_out_a, rf_d_out_b,
    output cmd_ready, rf_rd_addr_a, rf_rd_addr_b, rf_wr, rf_wr_addr, rf_d_in,
    output done, result, carry, zero
  );
endinterface

// File: rtl/reg_file_seq.sv
// Command sequencer for the 8x16 register file: runs one command at a time
// and is the only writer of the file.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// READ  | source registers on the read ports, operands captured at cycle end
// WR1   | first (usually only) write of the command
// WR2   | second write of SWAP (src_b <- old src_a)
// CLEAR | writing zero to register clr_cnt, eight cycles
// DONE  | one-cycle done pulse, status outputs valid
module reg_file_seq #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input logic          clk,
  input logic          reset,
  reg_file_seq_if.slave bus
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_MOV  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WR1, S_WR2, S_CLEAR, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    op_q;
  logic [AW-1:0] dst_q, src_a_q, src_b_q, clr_cnt;
  logic [DW-1:0] imm_q, opa, opb, result_q;
  logic          carry_q, zero_q;
  logic          accept;
  logic [DW:0]   sum;
  logic [DW-1:0] wr1_data;
  logic          wr1_carry;

  assign accept = (state == S_IDLE) && bus.cmd_valid;
  assign sum    = {1'b0, opa} + {1'b0, opb};

  // Read ports always show the latched sources so READ needs no extra setup.
  assign bus.rf_rd_addr_a = src_a_q;
  assign bus.rf_rd_addr_b = src_b_q;
  assign bus.result       = result_q;
  assign bus.carry        = carry_q;
  assign bus.zero         = zero_q;

  // First-write data and carry/borrow for the latched opcode.
  always_comb begin
    wr1_data  = '0;
    wr1_carry = 1'b0;
    case (op_q)
      OP_LDI:  wr1_data = imm_q;
      OP_MOV:  wr1_data = opa;
      OP_ADD:  begin wr1_data = sum[DW-1:0]; wr1_carry = sum[DW]; end
      OP_SUB:  begin wr1_data = opa - opb;   wr1_carry = (opa < opb); end
      OP_AND:  wr1_data = opa & opb;
      OP_SWAP: wr1_data = opb;
      default: wr1_data = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_NOP:  state_nxt = S_DONE;
            OP_LDI:  state_nxt = S_WR1;
            OP_CLR:  state_nxt = S_CLEAR;
            default: state_nxt = S_READ;
          endcase
        end
      end
      S_READ:  state_nxt = S_WR1;
      S_WR1:   state_nxt = (op_q == OP_SWAP) ? S_WR2 : S_DONE;
      S_WR2:   state_nxt = S_DONE;
      S_CLEAR: state_nxt = (clr_cnt == {AW{1'b1}}) ? S_DONE : S_CLEAR;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state only, so reset drops rf_wr without a clock.
  always_comb begin
    bus.cmd_ready  = 1'b0;
    bus.rf_wr      = 1'b0;
    bus.rf_wr_addr = dst_q;
    bus.rf_d_in    = '0;
    bus.done       = 1'b0;
    case (state)
      S_IDLE: bus.cmd_ready = 1'b1;
      S_WR1: begin
        bus.rf_wr      = 1'b1;
        bus.rf_wr_addr = (op_q == OP_SWAP) ? src_a_q : dst_q;
        bus.rf_d_in    = wr1_data;
      end
      S_WR2: begin
        bus.rf_wr      = 1'b1;
        bus.rf_wr_addr = src_b_q;
        bus.rf_d_in    = opa;
      end
      S_CLEAR: begin
        bus.rf_wr      = 1'b1;
        bus.rf_wr_addr = clr_cnt;
      end
      S_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  // Command latch, operand capture, clear counter and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      dst_q    <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      imm_q    <= '0;
      opa      <= '0;
      opb      <= '0;
      clr_cnt  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= bus.cmd_op;
            dst_q   <= bus.cmd_dst;
            src_a_q <= bus.cmd_src_a;
            src_b_q <= bus.cmd_src_b;
            imm_q   <= bus.cmd_imm;
            clr_cnt <= '0;
          end
        end
        S_READ: begin
          opa <= bus.rf_d_out_a;
          opb <= bus.rf_d_out_b;
        end
        S_WR1: begin
          result_q <= wr1_data;
          carry_q  <= wr1_carry;
          zero_q   <= (wr1_data == '0);
        end
        S_WR2: begin
          result_q <= opa;
          carry_q  <= 1'b0;
          zero_q   <= (opa == '0);
        end
        S_CLEAR: begin
          clr_cnt  <= clr_cnt + 1'b1;
          result_q <= '0;
          carry_q  <= 1'b0;
          zero_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/reg_file_seq.md
Name: reg_file_seq

Overview:
Command sequencer for the 8x16 register file (2 combinational read ports, 1 clocked write port).
- Accepts one command at a time over a valid/ready handshake.
- Drives the file's read addresses, write enable, write address and write data to execute load-immediate, move, ALU, swap and clear-all operations.
- Sits between the control unit and the register file, and is the only writer of the file.

Parameters:
- DW, 16, data width (matches register file).
- AW, 3, register address width (8 registers).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode: 0 NOP, 1 LDI, 2 MOV, 3 ADD, 4 SUB, 5 AND, 6 SWAP, 7 CLR.
- cmd_dst  in  AW  destination register.
- cmd_src_a  in  AW  source A.
- cmd_src_b  in  AW  source B.
- cmd_imm  in  DW  immediate for LDI.
- rf_rd_addr_a  out  AW  to register file read port A.
- rf_rd_addr_b  out  AW  to register file read port B.
- rf_d_out_a  in  DW  from register file port A.
- rf_d_out_b  in  DW  from register file port B.
- rf_wr  out  1  register file write enable.
- rf_wr_addr  out  AW  register file write address.
- rf_d_in  out  DW  register file write data.
- done  out  1  one-cycle pulse, command complete.
- result  out  DW  last value written (SWAP: value written to src_b; CLR: 0).
- carry  out  1  ADD carry-out / SUB borrow; 0 for other ops.
- zero  out  1  result == 0.

Behaviour:
- FSM states: IDLE, READ, WR1, WR2, CLEAR, DONE. State register and all data registers reset asynchronously when reset=0.
- Reset values: state=IDLE, latched command=0, opa=opb=0, clr_cnt=0, result=0, carry=0, zero=0. Outputs during reset: rf_wr=0, done=0, cmd_ready=1.
- cmd_ready=1 only in IDLE. A command is accepted on the rising edge with cmd_valid & cmd_ready; op, dst, src_a, src_b and imm are latched then.
- Transitions on accept:
  - NOP -> DONE.
  - LDI -> WR1.
  - CLR -> CLEAR, clr_cnt=0.
  - All others -> READ.
- READ (1 cycle): rf_rd_addr_a=src_a, rf_rd_addr_b=src_b; opa/opb captured at the end of the cycle. -> WR1.
- WR1 (1 cycle): rf_wr=1, rf_wr_addr=dst, except SWAP where rf_wr_addr=src_a.
  - rf_d_in: LDI imm; MOV opa; ADD opa+opb mod 2^16; SUB opa-opb mod 2^16; AND opa&opb; SWAP opb.
  - carry captured: ADD bit 16 of the 17-bit sum; SUB 1 when opa<opb (unsigned).
  - SWAP -> WR2; otherwise -> DONE.
- WR2 (SWAP only): rf_wr=1, rf_wr_addr=src_b, rf_d_in=opa. -> DONE. SWAP with src_a==src_b leaves the register unchanged.
- CLEAR: rf_wr=1, rf_wr_addr=clr_cnt, rf_d_in=0; clr_cnt increments each cycle. Stays in CLEAR 8 cycles; at clr_cnt==7 -> DONE. clr_cnt wraps to 0.
- DONE (1 cycle): done=1, result/carry/zero valid and held until the next write. -> IDLE.
- Outside write states: rf_wr=0. rf_rd_addr_a/b hold the latched src_a/src_b in all states.
- Latencies, counted from the accept edge to the done cycle:
  - NOP: 1 cycle.
  - LDI: 2 cycles (write at the first edge after accept).
  - MOV/ADD/SUB/AND: 3 cycles.
  - SWAP: 4 cycles.
  - CLR: 9 cycles.
- Back-to-back throughput: the next command is accepted no earlier than the cycle after DONE.
- Reads of a register written by the previous command return the new value (write has committed before READ).
- reset asserted mid-operation: FSM returns to IDLE immediately and rf_wr deasserts asynchronously. A partial CLR or SWAP is not completed and the register file contents are as left.
- cmd_valid while busy is ignored (no latch), and must be held by the requester.
- Opcode values are fully decoded; no illegal opcodes.

Test Plan:
- Reset: hold reset=0 with cmd_valid=1 -> rf_wr=0, done=0, cmd_ready=1. Release reset -> first command accepted on the next edge.
- LDI r3=0x1234, then MOV r5<-r3 -> two writes with rf_wr_addr 3 then 5, both rf_d_in=0x1234. done pulses 2 and 3 cycles after the respective accepts.
- LDI r1=0xFFFF, LDI r2=0x0001, ADD r0=r1+r2 -> write r0=0x0000, carry=1, zero=1. Then SUB r4=r2-r1 -> 0x0002, carry=1.
- LDI r6=0xAAAA, LDI r7=0x5555, SWAP r6,r7 -> WR1 writes r6=0x5555, WR2 writes r7=0xAAAA, result=0xAAAA, 4-cycle latency.
- CLR -> rf_wr high exactly 8 consecutive cycles, rf_wr_addr sequence 0..7, rf_d_in=0. done on the 9th cycle. cmd_ready=0 throughout.
- Assert reset during the 4th CLEAR cycle -> rf_wr drops immediately and state=IDLE after release. Registers 0-2 (and 3 if the edge occurred) are cleared; the rest are unchanged.
